// File: rtl/qkv_seq_ctrl.sv
// QKV projection sequencer: streams tokens from the token buffer through one engine
// instance and writes each token's Q/K/V results into the KV buffer.
module qkv_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int EMBED_DIM  = 64,
  parameter int MAX_SEQ    = 16,
  parameter int TIMEOUT    = 8192
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [$clog2(MAX_SEQ+1)-1:0]        cfg_len,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic                                tok_rd_en,
  output logic [$clog2(MAX_SEQ)-1:0]          tok_rd_addr,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0]     tok_rd_data,
  output logic                                eng_start,
  output logic [DATA_WIDTH*EMBED_DIM-1:0]     eng_in_flat,
  input  logic                                eng_done,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0]     eng_q_flat,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0]     eng_k_flat,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0]     eng_v_flat,
  output logic                                wr_en,
  output logic [$clog2(MAX_SEQ)-1:0]          wr_idx,
  output logic [DATA_WIDTH*EMBED_DIM-1:0]     wr_q_flat,
  output logic [DATA_WIDTH*EMBED_DIM-1:0]     wr_k_flat,
  output logic [DATA_WIDTH*EMBED_DIM-1:0]     wr_v_flat
);
  localparam int LEN_W = $clog2(MAX_SEQ+1);
  localparam int IDX_W = $clog2(MAX_SEQ);
  localparam int WD_W  = $clog2(TIMEOUT+1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SEQ);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT-1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, LAUNCH, WAIT_ENG, WRITE, FINISH} state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [IDX_W-1:0] t;
  logic [WD_W-1:0]  wd;
  logic [LEN_W-1:0] len_clamped;
  logic             last_tok;

  assign len_clamped = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
  assign last_tok    = (LEN_W'(t) == len - LEN_W'(1));

  // Strobes default low every cycle and are set on the edge entering their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      t           <= '0;
      wd          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tok_rd_en   <= 1'b0;
      tok_rd_addr <= '0;
      eng_start   <= 1'b0;
      eng_in_flat <= '0;
      wr_en       <= 1'b0;
      wr_idx      <= '0;
      wr_q_flat   <= '0;
      wr_k_flat   <= '0;
      wr_v_flat   <= '0;
    end else begin
      tok_rd_en <= 1'b0;
      eng_start <= 1'b0;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              len  <= len_clamped;
              err  <= 1'b0;
              t    <= '0;
              busy <= 1'b1;
              if (len_clamped == '0) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                state       <= FETCH;
                tok_rd_en   <= 1'b1;
                tok_rd_addr <= '0;
              end
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            eng_in_flat <= tok_rd_data;
            eng_start   <= 1'b1;
            state       <= LAUNCH;
          end
          LAUNCH: begin
            wd    <= '0;
            state <= WAIT_ENG;
          end
          WAIT_ENG: begin
            // A completion in the final watchdog cycle still wins over the timeout.
            if (eng_done) begin
              wr_q_flat <= eng_q_flat;
              wr_k_flat <= eng_k_flat;
              wr_v_flat <= eng_v_flat;
              wr_en     <= 1'b1;
              wr_idx    <= t;
              state     <= WRITE;
            end else if (wd == WD_LAST) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              wd <= wd + WD_W'(1);
            end
          end
          WRITE: begin
            if (last_tok) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              t           <= t + IDX_W'(1);
              tok_rd_addr <= t + IDX_W'(1);
              tok_rd_en   <= 1'b1;
              state       <= FETCH;
            end
          end
          FINISH: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qkv_seq_ctrl.sv
// Self-checking bench for qkv_seq_ctrl: token buffer and engine models plus an
// event-level reference that predicts each strobe's cycle, index and payload.
`timescale 1ns/1ps
module tb_qkv_seq_ctrl;
  localparam int DW = 32;
  localparam int ED = 64;
  localparam int VW = DW * ED;
  localparam int MS = 16;
  localparam int TO = 16;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [4:0]    cfg_len = '0;
  logic          busy, done, err, tok_rd_en, eng_start, wr_en;
  logic [3:0]    tok_rd_addr, wr_idx;
  logic [VW-1:0] tok_rd_data = '0, eng_in_flat;
  logic          eng_done = 1'b0;
  logic [VW-1:0] eng_q_flat = '0, eng_k_flat = '0, eng_v_flat = '0;
  logic [VW-1:0] wr_q_flat, wr_k_flat, wr_v_flat;

  qkv_seq_ctrl #(.DATA_WIDTH(DW), .EMBED_DIM(ED), .MAX_SEQ(MS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err),
    .tok_rd_en(tok_rd_en), .tok_rd_addr(tok_rd_addr), .tok_rd_data(tok_rd_data),
    .eng_start(eng_start), .eng_in_flat(eng_in_flat), .eng_done(eng_done),
    .eng_q_flat(eng_q_flat), .eng_k_flat(eng_k_flat), .eng_v_flat(eng_v_flat),
    .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_q_flat(wr_q_flat), .wr_k_flat(wr_k_flat), .wr_v_flat(wr_v_flat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int i = 0; i < ED; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // Engine transfer functions: any distinct per-output mapping exposes mixed-up lanes.
  function automatic logic [VW-1:0] engQ(input logic [VW-1:0] x);
    return x ^ {ED{32'h5A5A_0001}};
  endfunction
  function automatic logic [VW-1:0] engK(input logic [VW-1:0] x);
    return ~x;
  endfunction
  function automatic logic [VW-1:0] engV(input logic [VW-1:0] x);
    return {x[VW/2-1:0], x[VW-1:VW/2]};
  endfunction

  function automatic int firstDiff(input logic [VW-1:0] a, input logic [VW-1:0] b);
    for (int i = 0; i < ED; i++) if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
    return 0;
  endfunction

  task automatic checkVec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    int i;
    i = firstDiff(got, exp);
    checkOutput(tag, 64'(got[i*DW +: DW]), 64'(exp[i*DW +: DW]));
  endtask

  // Reference state: what the current run should do next, and when.
  logic [VW-1:0] tok_mem [MS];
  int  mlen = 0, mt = 0, n_wr = 0, n_done = 0;
  bit  run_active = 1'b0, aborted = 1'b0;
  int  exp_fetch = -1, exp_start = -1, exp_wr = -1, exp_done = -1, exp_idle = -1, exp_err = -1;
  int  eng_fixed_delay = 0, abort_tok = -1, abort_at = -1, eng_cnt = 0;
  bit  eng_hang = 1'b0, eng_pend = 1'b0, rd_pend = 1'b0, abort_now;
  logic [VW-1:0] eng_cap;
  logic [3:0]    rd_addr = '0;

  task automatic clearExpect();
    exp_fetch = -1; exp_start = -1; exp_wr = -1; exp_done = -1; exp_idle = -1; exp_err = -1;
  endtask

  // Mid-cycle: check strobes against predictions, then advance buffer/engine models.
  always @(negedge clk) begin
    abort     = 1'b0;
    eng_done  = 1'b0;
    abort_now = 1'b0;
    if (rst) begin
      clearExpect();
      run_active = 1'b0;
      eng_pend   = 1'b0;
      rd_pend    = 1'b0;
    end else begin
      if (tok_rd_en || cyc == exp_fetch) begin
        checkOutput("tok_rd_en_timing", 64'(tok_rd_en), 64'(cyc == exp_fetch));
        if (tok_rd_en) begin
          checkOutput("tok_rd_addr", 64'(tok_rd_addr), 64'(mt));
          exp_fetch = -1;
          exp_start = cyc + 2;
        end
      end
      if (eng_pend) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_pend   = 1'b0;
          eng_done   = 1'b1;
          eng_q_flat = engQ(eng_cap);
          eng_k_flat = engK(eng_cap);
          eng_v_flat = engV(eng_cap);
          if (run_active) begin
            if (abort_tok == mt) abort_now = 1'b1;
            else exp_wr = cyc + 1;
          end
        end
      end
      if (eng_start || cyc == exp_start) begin
        checkOutput("eng_start_timing", 64'(eng_start), 64'(cyc == exp_start));
        if (eng_start) begin
          checkVec("eng_in_flat", eng_in_flat, tok_mem[mt]);
          exp_start  = -1;
          eng_cap    = eng_in_flat;
          eng_q_flat = randVec();
          eng_k_flat = randVec();
          eng_v_flat = randVec();
          if (eng_hang) exp_err = cyc + TO + 1;
          else begin
            eng_pend = 1'b1;
            eng_cnt  = (eng_fixed_delay > 0) ? eng_fixed_delay : int'($urandom_range(1, 8));
          end
        end
      end
      if (exp_err >= 0 && cyc == exp_err - 1) checkOutput("err_before_timeout", 64'(err), 64'(0));
      if (exp_err >= 0 && cyc == exp_err) begin
        checkOutput("err_timeout", 64'(err), 64'(1));
        checkOutput("busy_timeout", 64'(busy), 64'(0));
        exp_err    = -1;
        run_active = 1'b0;
      end
      if (wr_en || cyc == exp_wr) begin
        checkOutput("wr_en_timing", 64'(wr_en), 64'(cyc == exp_wr));
        if (wr_en) begin
          n_wr++;
          checkOutput("wr_idx", 64'(wr_idx), 64'(mt));
          checkOutput("busy_in_run", 64'(busy), 64'(1));
          checkVec("wr_q_flat", wr_q_flat, engQ(tok_mem[mt]));
          checkVec("wr_k_flat", wr_k_flat, engK(tok_mem[mt]));
          checkVec("wr_v_flat", wr_v_flat, engV(tok_mem[mt]));
          checkVec("eng_in_hold", eng_in_flat, tok_mem[mt]);
          exp_wr = -1;
          if (mt == mlen - 1) exp_done = cyc + 1;
          else begin
            mt++;
            exp_fetch = cyc + 1;
          end
        end
      end
      if (done || cyc == exp_done) begin
        checkOutput("done_timing", 64'(done), 64'(cyc == exp_done));
        if (done) begin
          n_done++;
          exp_done   = -1;
          exp_idle   = cyc + 1;
          run_active = 1'b0;
        end
      end
      if (exp_idle >= 0 && cyc == exp_idle) begin
        checkOutput("busy_idle", 64'(busy), 64'(0));
        checkOutput("err_idle", 64'(err), 64'(0));
        exp_idle = -1;
      end
      tok_rd_data = rd_pend ? tok_mem[rd_addr] : randVec();
      rd_pend     = tok_rd_en;
      rd_addr     = tok_rd_addr;
      if (run_active && (abort_now || cyc == abort_at)) begin
        abort = 1'b1;
        clearExpect();
        exp_idle   = cyc + 1;
        run_active = 1'b0;
        aborted    = 1'b1;
      end
    end
  end

  task automatic launchRun(input int len, input bit pattern, input int fixed_delay,
                           input bit hang, input int ab_tok, input int ab_off);
    logic [31:0] e;
    @(negedge clk);
    for (int i = 0; i < MS; i++) begin
      e = 32'h1000 * 32'(i + 1);
      tok_mem[i] = pattern ? {ED{e}} : randVec();
    end
    eng_fixed_delay = fixed_delay;
    eng_hang        = hang;
    abort_tok       = ab_tok;
    abort_at        = (ab_off > 0) ? cyc + ab_off : -1;
    aborted         = 1'b0;
    mlen            = (len > MS) ? MS : len;
    mt              = 0;
    n_wr            = 0;
    n_done          = 0;
    cfg_len         = 5'(len);
    start           = 1'b1;
    if (mlen == 0) exp_done = cyc + 1;
    else exp_fetch = cyc + 1;
    run_active = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cfg_len = 5'($urandom_range(0, 31));
    checkOutput("busy_after_start", 64'(busy), 64'(1));
    checkOutput("err_after_start", 64'(err), 64'(0));
  endtask

  task automatic applyStimulus(input int len, input bit pattern, input int fixed_delay,
                               input bit hang, input int ab_tok, input int ab_off);
    int lim, inj;
    launchRun(len, pattern, fixed_delay, hang, ab_tok, ab_off);
    lim = 0;
    inj = $urandom_range(2, 10);
    while (run_active && lim < 1500) begin
      @(negedge clk);
      start = 1'b0;
      lim++;
      if (lim == inj && busy) begin
        start   = 1'b1;
        cfg_len = 5'($urandom_range(0, 31));
      end
    end
    start = 1'b0;
    checkOutput("run_completes", 64'(run_active), 64'(0));
    if (run_active) begin
      clearExpect();
      run_active = 1'b0;
    end
    repeat (20) @(negedge clk);
    checkOutput("busy_final", 64'(busy), 64'(0));
    checkOutput("err_final", 64'(err), 64'(hang));
    checkOutput("done_count", 64'(n_done), 64'((hang || aborted) ? 0 : 1));
    if (!aborted) checkOutput("write_count", 64'(n_wr), 64'(hang ? 0 : mlen));
    else if (ab_tok >= 0) checkOutput("write_count_abort", 64'(n_wr), 64'(ab_tok));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_err"}, 64'(err), 64'(0));
    checkOutput({tag, "_tok_rd_en"}, 64'(tok_rd_en), 64'(0));
    checkOutput({tag, "_eng_start"}, 64'(eng_start), 64'(0));
    checkOutput({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    checkOutput({tag, "_tok_rd_addr"}, 64'(tok_rd_addr), 64'(0));
    checkOutput({tag, "_wr_idx"}, 64'(wr_idx), 64'(0));
    checkVec({tag, "_eng_in"}, eng_in_flat, '0);
    checkVec({tag, "_wr_q"}, wr_q_flat, '0);
    checkVec({tag, "_wr_k"}, wr_k_flat, '0);
    checkVec({tag, "_wr_v"}, wr_v_flat, '0);
  endtask

  task automatic resetMidWrite();
    int lim;
    launchRun(4, 1'b0, 0, 1'b0, -1, 0);
    lim = 0;
    while (!(wr_en && wr_idx == 4'd1) && lim < 300) begin
      @(negedge clk);
      lim++;
    end
    checkOutput("reached_write", 64'(wr_en && wr_idx == 4'd1), 64'(1));
    #1 rst = 1'b1;
    #1 checkAllZero("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("done_after_rst", 64'(n_done), 64'(0));
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b1;
    #20 checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(3, 1'b1, 3, 1'b0, -1, 0);
    applyStimulus(0, 1'b0, 0, 1'b0, -1, 0);
    applyStimulus(20, 1'b0, 0, 1'b0, -1, 0);
    applyStimulus(2, 1'b0, TO, 1'b0, -1, 0);
    applyStimulus(2, 1'b0, 0, 1'b1, -1, 0);
    applyStimulus(3, 1'b0, 0, 1'b0, -1, 0);
    applyStimulus(4, 1'b0, 0, 1'b0, 1, 0);
    resetMidWrite();
    applyStimulus(3, 1'b1, 2, 1'b0, -1, 0);

    for (int r = 0; r < 12; r++) begin
      int len, off;
      len = $urandom_range(0, 20);
      off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
      applyStimulus(len, 1'b0, 0, 1'b0, -1, off);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
